// File: rtl/alu_mlal_sequencer.sv
// Multi-cycle sequencer placed in front of ALUComb for long multiply-accumulate.
// An incoming MLAL is split into a held multiply step (MLALMul) followed by a
// single accumulate step (MLALAdd). The execute stage is stalled until the
// accumulate cycle. Every other ALU type is forwarded combinationally.
module alu_mlal_sequencer #(
    parameter int                    WORD_WIDTH   = 32,
    parameter int                    TYPE_WIDTH   = 8,
    parameter int                    MUL_CYCLES   = 1,
    parameter logic [TYPE_WIDTH-1:0] CODE_MLAL    = 8'h20,
    parameter logic [TYPE_WIDTH-1:0] CODE_MLALMUL = 8'h21,
    parameter logic [TYPE_WIDTH-1:0] CODE_MLALADD = 8'h22,
    parameter logic [TYPE_WIDTH-1:0] CODE_NOP     = 8'hFF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_Valid,
    input  logic [TYPE_WIDTH-1:0] in_ALUType,
    input  logic [WORD_WIDTH-1:0] in_LeftOperand,
    input  logic [WORD_WIDTH-1:0] in_RightOperand,
    input  logic [WORD_WIDTH-1:0] in_ThirdOperand,
    input  logic [WORD_WIDTH-1:0] in_FourthOperand,
    input  logic                  in_LongMulSig,
    input  logic                  in_Flush,
    output logic [TYPE_WIDTH-1:0] out_ALUType,
    output logic [WORD_WIDTH-1:0] out_LeftOperand,
    output logic [WORD_WIDTH-1:0] out_RightOperand,
    output logic [WORD_WIDTH-1:0] out_ThirdOperand,
    output logic                  out_LongMulSig,
    output logic                  out_Stall,
    output logic                  out_Done,
    output logic                  out_Busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_ADD  = 2'd2
    } state_t;

    // Multiply hold counter; 4 bits covers the supported 1..15 hold cycles.
    localparam logic [3:0] COUNT_LOAD = 4'(MUL_CYCLES - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [3:0]            r_count;
    logic [3:0]            w_count_next;

    // Operands captured on the accept edge; the execute stage may change its
    // inputs freely while we are in MUL.
    logic [WORD_WIDTH-1:0] r_rm;
    logic [WORD_WIDTH-1:0] r_rs;
    logic [WORD_WIDTH-1:0] r_rdlo;
    logic [WORD_WIDTH-1:0] r_rdhi;
    logic                  r_sig;

    logic                  w_start;

    // Accept an MLAL only from IDLE, outside reset, and not in a flushed cycle.
    assign w_start = reset && (r_state == S_IDLE) && in_Valid &&
                     (in_ALUType == CODE_MLAL) && !in_Flush;

    assign out_Busy = (r_state != S_IDLE);

    // State register and multiply hold counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
        end
    end

    // Operand capture on the accept edge only.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rm   <= '0;
            r_rs   <= '0;
            r_rdlo <= '0;
            r_rdhi <= '0;
            r_sig  <= 1'b0;
        end else if (w_start) begin
            r_rm   <= in_LeftOperand;
            r_rs   <= in_RightOperand;
            r_rdlo <= in_ThirdOperand;
            r_rdhi <= in_FourthOperand;
            r_sig  <= in_LongMulSig;
        end
    end

    // Next-state and ALUComb drive; pass-through is the default behaviour.
    always_comb begin
        w_state_next     = r_state;
        w_count_next     = r_count;
        out_ALUType      = in_ALUType;
        out_LeftOperand  = in_LeftOperand;
        out_RightOperand = in_RightOperand;
        out_ThirdOperand = in_ThirdOperand;
        out_LongMulSig   = in_LongMulSig;
        out_Stall        = 1'b0;
        out_Done         = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    // ALUComb must not act on the raw MLAL code in the accept cycle.
                    out_ALUType  = CODE_NOP;
                    out_Stall    = 1'b1;
                    w_state_next = S_MUL;
                    w_count_next = COUNT_LOAD;
                end
            end
            S_MUL: begin
                out_ALUType      = CODE_MLALMUL;
                out_LeftOperand  = r_rm;
                out_RightOperand = r_rs;
                out_ThirdOperand = '0;
                out_LongMulSig   = r_sig;
                out_Stall        = 1'b1;
                if (r_count == 4'd0) begin
                    w_state_next = S_ADD;
                end else begin
                    w_count_next = r_count - 4'd1;
                end
            end
            S_ADD: begin
                // ALUComb adds {RdHi,RdLo} to its latched product; the stage
                // advances with that result, so no stall here.
                out_ALUType      = CODE_MLALADD;
                out_LeftOperand  = r_rdlo;
                out_RightOperand = r_rdhi;
                out_ThirdOperand = '0;
                out_LongMulSig   = r_sig;
                out_Done         = !in_Flush;
                w_state_next     = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // A flush abandons whatever sequence is in progress.
        if (in_Flush) begin
            w_state_next = S_IDLE;
        end
    end

endmodule

// File: tb/tb_alu_mlal_sequencer.sv
// Bench for alu_mlal_sequencer: two instances (multiply held 1 and 3 cycles)
// share the same stimulus. A timeline model (accept cycle + captured
// operands) predicts every output each cycle, and a small ALUComb model turns
// the DUT's MLALMul/MLALAdd drive into a 64-bit result checked on Done.
module tb_alu_mlal_sequencer;

    localparam int      NDUT = 2;
    localparam int      MC0  = 1;
    localparam int      MC1  = 3;
    localparam logic [7:0] T_MLAL = 8'h20;
    localparam logic [7:0] T_MUL  = 8'h21;
    localparam logic [7:0] T_ADD  = 8'h22;
    localparam logic [7:0] T_NOP  = 8'hFF;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_Valid;
    logic [7:0]  in_ALUType;
    logic [31:0] in_L, in_R, in_T, in_F;
    logic        in_Sig;
    logic        in_Flush;

    logic [7:0]  o_type  [NDUT];
    logic [31:0] o_left  [NDUT];
    logic [31:0] o_right [NDUT];
    logic [31:0] o_third [NDUT];
    logic        o_sig   [NDUT];
    logic        o_stall [NDUT];
    logic        o_done  [NDUT];
    logic        o_busy  [NDUT];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model state per instance
    bit          in_seq    [NDUT];
    int          acc       [NDUT];
    logic [31:0] c_rm [NDUT], c_rs [NDUT], c_lo [NDUT], c_hi [NDUT];
    bit          c_sig     [NDUT];
    logic [63:0] mreg      [NDUT];
    logic [63:0] last_res  [NDUT];
    int          done_cnt  [NDUT];
    int          stall_cnt [NDUT];

    always #5 clock = ~clock;

    alu_mlal_sequencer #(.MUL_CYCLES(MC0)) u_dut0 (
        .clock(clock), .reset(reset), .in_Valid(in_Valid), .in_ALUType(in_ALUType),
        .in_LeftOperand(in_L), .in_RightOperand(in_R), .in_ThirdOperand(in_T),
        .in_FourthOperand(in_F), .in_LongMulSig(in_Sig), .in_Flush(in_Flush),
        .out_ALUType(o_type[0]), .out_LeftOperand(o_left[0]), .out_RightOperand(o_right[0]),
        .out_ThirdOperand(o_third[0]), .out_LongMulSig(o_sig[0]), .out_Stall(o_stall[0]),
        .out_Done(o_done[0]), .out_Busy(o_busy[0])
    );

    alu_mlal_sequencer #(.MUL_CYCLES(MC1)) u_dut1 (
        .clock(clock), .reset(reset), .in_Valid(in_Valid), .in_ALUType(in_ALUType),
        .in_LeftOperand(in_L), .in_RightOperand(in_R), .in_ThirdOperand(in_T),
        .in_FourthOperand(in_F), .in_LongMulSig(in_Sig), .in_Flush(in_Flush),
        .out_ALUType(o_type[1]), .out_LeftOperand(o_left[1]), .out_RightOperand(o_right[1]),
        .out_ThirdOperand(o_third[1]), .out_LongMulSig(o_sig[1]), .out_Stall(o_stall[1]),
        .out_Done(o_done[1]), .out_Busy(o_busy[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // 64-bit product as the long multiplier produces it.
    function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b, input bit s);
        logic [63:0] ae, be;
        ae = s ? {{32{a[31]}}, a} : {32'b0, a};
        be = s ? {{32{b[31]}}, b} : {32'b0, b};
        return ae * be;
    endfunction

    // Compare process: every cycle, 2 time units after the rising edge.
    always @(posedge clock) begin
        #2;
        for (int k = 0; k < NDUT; k++) begin
            int          m, ph;
            bit          start, is_add;
            logic [7:0]  e_type;
            logic [31:0] e_l, e_r, e_t;
            bit          e_sig, e_stall, e_done, e_busy;
            logic [63:0] res;
            m      = (k == 0) ? MC0 : MC1;
            ph     = cyc - acc[k];
            is_add = 1'b0;
            start  = reset && !in_seq[k] && in_Valid && (in_ALUType == T_MLAL) && !in_Flush;
            if (!reset || !in_seq[k]) begin
                e_type = start ? T_NOP : in_ALUType;
                e_l = in_L; e_r = in_R; e_t = in_T; e_sig = in_Sig;
                e_stall = start; e_done = 1'b0; e_busy = 1'b0;
            end else if (ph <= m) begin
                e_type = T_MUL; e_l = c_rm[k]; e_r = c_rs[k]; e_t = '0; e_sig = c_sig[k];
                e_stall = 1'b1; e_done = 1'b0; e_busy = 1'b1;
            end else begin
                is_add = 1'b1;
                e_type = T_ADD; e_l = c_lo[k]; e_r = c_hi[k]; e_t = '0; e_sig = c_sig[k];
                e_stall = 1'b0; e_done = !in_Flush; e_busy = 1'b1;
            end
            chk($sformatf("type%0d", k), 64'(o_type[k]), 64'(e_type));
            chk($sformatf("left%0d", k), 64'(o_left[k]), 64'(e_l));
            chk($sformatf("right%0d", k), 64'(o_right[k]), 64'(e_r));
            if (!is_add) begin
                chk($sformatf("third%0d", k), 64'(o_third[k]), 64'(e_t));
                chk($sformatf("sig%0d", k), 64'(o_sig[k]), 64'(e_sig));
            end
            chk($sformatf("stall%0d", k), 64'(o_stall[k]), 64'(e_stall));
            chk($sformatf("done%0d", k), 64'(o_done[k]), 64'(e_done));
            chk($sformatf("busy%0d", k), 64'(o_busy[k]), 64'(e_busy));

            // ALUComb model: MLALMul latches the product, MLALAdd adds {Hi,Lo}.
            if (o_done[k]) begin
                res = mreg[k] + {o_right[k], o_left[k]};
                chk($sformatf("result%0d", k), res,
                    prod(c_rm[k], c_rs[k], c_sig[k]) + {c_hi[k], c_lo[k]});
                last_res[k] = res;
                done_cnt[k]++;
                $display("dut%0d MLAL done cyc=%0d result=%016h", k, cyc, res);
            end
            if (o_type[k] == T_MUL) mreg[k] = prod(o_left[k], o_right[k], o_sig[k]);
            if (o_stall[k]) stall_cnt[k]++;

            // Advance the model across the coming edge.
            if (!reset) begin
                in_seq[k] = 1'b0;
            end else if (in_seq[k]) begin
                if (in_Flush || ph == m + 1) in_seq[k] = 1'b0;
            end else if (start) begin
                in_seq[k] = 1'b1;
                acc[k]    = cyc;
                c_rm[k] = in_L; c_rs[k] = in_R; c_lo[k] = in_T; c_hi[k] = in_F;
                c_sig[k] = in_Sig;
            end
        end
        cyc++;
    end

    task automatic drive(input bit rst, input bit v, input logic [7:0] t,
                         input logic [31:0] l, input logic [31:0] r,
                         input logic [31:0] th, input logic [31:0] fo,
                         input bit s, input bit fl);
        @(posedge clock);
        #1;
        reset = rst; in_Valid = v; in_ALUType = t;
        in_L = l; in_R = r; in_T = th; in_F = fo; in_Sig = s; in_Flush = fl;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 8'h01, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic clear_counts();
        for (int k = 0; k < NDUT; k++) begin
            done_cnt[k]  = 0;
            stall_cnt[k] = 0;
        end
    endtask

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            in_seq[k] = 1'b0; acc[k] = 0; mreg[k] = '0; last_res[k] = '0;
            c_rm[k] = '0; c_rs[k] = '0; c_lo[k] = '0; c_hi[k] = '0; c_sig[k] = 1'b0;
        end
        clear_counts();
        // In reset an MLAL request must still pass straight through.
        reset = 1'b0; in_Valid = 1'b1; in_ALUType = T_MLAL;
        in_L = 32'h11; in_R = 32'h22; in_T = 32'h33; in_F = 32'h44; in_Sig = 1'b0; in_Flush = 1'b0;
        #3;
        chk("rst_type", 64'(o_type[0]), 64'(T_MLAL));
        chk("rst_stall", 64'(o_stall[0]), 64'd0);
        chk("rst_busy", 64'(o_busy[1]), 64'd0);
        drive(1'b0, 1'b1, T_MLAL, 32'h11, 32'h22, 32'h33, 32'h44, 1'b0, 1'b0);
        idle(2);

        // Pass-through of an ordinary ALU type.
        drive(1'b1, 1'b1, 8'h01, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0);
        #2;
        chk("pt_type", 64'(o_type[0]), 64'h01);
        chk("pt_left", 64'(o_left[0]), 64'd5);
        chk("pt_right", 64'(o_right[1]), 64'd7);
        chk("pt_stall", 64'(o_stall[1]), 64'd0);

        // Single MLAL: 0xFFFFFFFF*2 + 1.
        clear_counts();
        drive(1'b1, 1'b1, T_MLAL, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'd0, 1'b0, 1'b0);
        #2;
        chk("acc_nop", 64'(o_type[0]), 64'(T_NOP));
        idle(6);
        #2;
        chk("m1_done_cnt", 64'(done_cnt[0]), 64'd1);
        chk("m3_done_cnt", 64'(done_cnt[1]), 64'd1);
        chk("m1_result", last_res[0], 64'h0000_0001_FFFF_FFFF);
        chk("m3_result", last_res[1], 64'h0000_0001_FFFF_FFFF);
        chk("m1_stall_len", 64'(stall_cnt[0]), 64'd2);
        chk("m3_stall_len", 64'(stall_cnt[1]), 64'd4);

        // Flush during MUL, then a fresh MLAL straight after: 3*4 + 5.
        clear_counts();
        drive(1'b1, 1'b1, T_MLAL, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'd0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 8'h01, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, T_MLAL, 32'd3, 32'd4, 32'd5, 32'd0, 1'b0, 1'b0);
        idle(6);
        #2;
        chk("flush_done_cnt0", 64'(done_cnt[0]), 64'd1);
        chk("flush_done_cnt1", 64'(done_cnt[1]), 64'd1);
        chk("flush_result1", last_res[1], 64'd17);

        // Reset asserted during MUL: no Done afterwards.
        clear_counts();
        drive(1'b1, 1'b1, T_MLAL, 32'd9, 32'd9, 32'd9, 32'd9, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'h03, 32'd1, 32'd2, 32'd3, 32'd4, 1'b0, 1'b0);
        #2;
        chk("rmid_busy", 64'(o_busy[1]), 64'd0);
        chk("rmid_type", 64'(o_type[0]), 64'h03);
        drive(1'b1, 1'b0, 8'h01, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        idle(5);
        #2;
        chk("rmid_no_done", 64'(done_cnt[0] + done_cnt[1]), 64'd0);

        // Back-to-back: the second MLAL is held on the inputs until accepted.
        clear_counts();
        drive(1'b1, 1'b1, T_MLAL, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < MC1 + 2; i++)
            drive(1'b1, 1'b1, T_MLAL, 32'h10, 32'h10, 32'd4, 32'd3, 1'b0, 1'b0);
        idle(6);
        #2;
        chk("b2b_done_cnt0", 64'(done_cnt[0]), 64'd2);
        chk("b2b_done_cnt1", 64'(done_cnt[1]), 64'd2);
        chk("b2b_result0", last_res[0], 64'h0000_0003_0000_0104);
        chk("b2b_result1", last_res[1], 64'h0000_0003_0000_0104);

        // Randomized traffic with occasional flushes, signed mode and resets.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 63) != 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) == 0) ? T_MLAL : 8'($urandom),
                  $urandom, $urandom, $urandom, $urandom,
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 15) == 0));
        end
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
